// File: rtl/sweep_pkg.sv
// Shared types and defaults for the vector sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sweep_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int OUTW_DEF  = 1;
  localparam int HOLD_DEF  = 10;
  localparam int TMR_W     = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_APPLY     = 3'd1,
    S_SAMPLE    = 3'd2,
    S_WAIT_STEP = 3'd3,
    S_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that paces how long each vector is held.
// Latency: load/decrement take effect on the next edge; zero is combinational.
// Backpressure: none; en simply pauses the count.
//
// Ports:
//   clk, rst_n  clock and async active-low reset (count resets to 0)
//   load        load load_val on the next edge (wins over en)
//   load_val    value to load
//   en          decrement by one per edge while non-zero
//   zero        high when the count after this edge's update is 0, so the
//               owner can change state on the same edge the count expires
module hold_timer
  import sweep_pkg::*;
#(
  parameter int TW = TMR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          en,
  output logic          zero
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_d == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vector_sweeper.sv
// Exhaustive stimulus sweeper: drives 0..2^WIDTH-1, compares DUT vs golden, counts errors.
// Latency: each vector held HOLD cycles; a full free-run sweep is 2^WIDTH*HOLD cycles.
// Backpressure: single-step mode parks in WAIT_STEP until a step pulse; abort always wins.
//
// Ports:
//   MAX10_CLK1_50  clock;  RESET_N  async active-low reset (release synchronised)
//   start/step_mode/step/abort  control pulses
//   vec            stimulus to DUT;  dut_resp/exp_resp  response and golden value
//   busy/done/pass status;  err_cnt  saturating mismatch count
// Optional macro VECTOR_SWEEPER_FAIL_CAPTURE_EN adds first_fail / first_fail_vld,
// capturing the vector of the first counted mismatch of a sweep.
module vector_sweeper
  import sweep_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OUTW  = OUTW_DEF,
  parameter int HOLD  = HOLD_DEF
) (
  input  logic             MAX10_CLK1_50,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             abort,
  output logic [WIDTH-1:0] vec,
  input  logic [OUTW-1:0]  dut_resp,
  input  logic [OUTW-1:0]  exp_resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_cnt
`ifdef VECTOR_SWEEPER_FAIL_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] first_fail,
  output logic             first_fail_vld
`endif
);

  localparam logic [WIDTH-1:0] VEC_MAX = '1;
  localparam logic [WIDTH:0]   ERR_MAX = '1;
  localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(HOLD - 1);

  // Reset asserts asynchronously through this flop and releases on the next
  // edge, so the FSM sees its first live edge one cycle after release.
  logic rst_q;

  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_q <= 1'b0;
    end else begin
      rst_q <= 1'b1;
    end
  end

  state_t           state;
  logic             mode_q;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_zero;
  logic             start_ok;
  logic             err_inc;
  logic [WIDTH:0]   err_nxt;

  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign err_inc  = (state == S_SAMPLE) && (dut_resp != exp_resp) && (err_cnt != ERR_MAX);
  assign err_nxt  = err_cnt + {{WIDTH{1'b0}}, err_inc};
  assign tmr_en   = (state == S_APPLY);

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = HOLD_LD;
    if (abort) begin
      tmr_load = 1'b1;
      tmr_val  = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: tmr_load = start;
        // free-run reload for the next vector; last vector and step mode don't reload here
        S_SAMPLE:       tmr_load = (vec != VEC_MAX) && !mode_q;
        S_WAIT_STEP:    tmr_load = step;
        default:        tmr_load = 1'b0;
      endcase
    end
  end

  hold_timer #(.TW(TMR_W)) u_hold_timer (
    .clk      (MAX10_CLK1_50),
    .rst_n    (rst_q),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge MAX10_CLK1_50 or negedge rst_q) begin
    if (!rst_q) begin
      state   <= S_IDLE;
      vec     <= '0;
      err_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      mode_q  <= 1'b0;
    end else if (abort) begin
      // err_cnt deliberately kept so the partial result stays readable
      state <= S_IDLE;
      vec   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_APPLY;
            vec     <= '0;
            err_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
            mode_q  <= step_mode;
          end
        end
        S_APPLY: begin
          if (tmr_zero) begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          err_cnt <= err_nxt;
          if (vec == VEC_MAX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else if (mode_q) begin
            state <= S_WAIT_STEP;
            busy  <= 1'b0;
          end else begin
            state <= S_APPLY;
            vec   <= vec + 1'b1;
          end
        end
        S_WAIT_STEP: begin
          if (step) begin
            state <= S_APPLY;
            vec   <= vec + 1'b1;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

`ifdef VECTOR_SWEEPER_FAIL_CAPTURE_EN
  always_ff @(posedge MAX10_CLK1_50 or negedge rst_q) begin
    if (!rst_q) begin
      first_fail     <= '0;
      first_fail_vld <= 1'b0;
    end else if (!abort) begin
      if (start_ok) begin
        first_fail     <= '0;
        first_fail_vld <= 1'b0;
      end else if (err_inc && !first_fail_vld) begin
        first_fail     <= vec;
        first_fail_vld <= 1'b1;
      end
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_vector_sweeper.sv
// Bench for vector_sweeper: WIDTH=4/HOLD=10 main instance plus a WIDTH=2/HOLD=3 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_vector_sweeper;

  localparam int W  = 4;
  localparam int H  = 10;
  localparam int OW = 1;
  localparam int W2 = 2;
  localparam int H2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, step_mode, step, abort;
  logic [W-1:0]  vec;
  logic [OW-1:0] dut_resp, exp_resp;
  logic          busy, done, pass;
  logic [W:0]    err_cnt;
  logic [15:0]   bad_mask;

  logic          start2;
  logic [W2-1:0] vec2;
  logic [OW-1:0] dut_resp2, exp_resp2;
  logic          busy2, done2, pass2;
  logic [W2:0]   err_cnt2;

`ifdef VECTOR_SWEEPER_FAIL_CAPTURE_EN
  logic [W-1:0]  first_fail;
  logic          first_fail_vld;
  logic [W2-1:0] first_fail2;
  logic          first_fail_vld2;
`endif

  // golden is an arbitrary function of vec; the DUT answer is flipped where bad_mask says
  always_comb begin
    exp_resp  = OW'(vec[1] ^ vec[3]);
    dut_resp  = exp_resp ^ OW'(bad_mask[vec]);
    exp_resp2 = OW'(vec2[0]);
    dut_resp2 = ~exp_resp2;
  end

  vector_sweeper #(.WIDTH(W), .OUTW(OW), .HOLD(H)) dut (
    .MAX10_CLK1_50 (clk),
    .RESET_N       (rst_n),
    .start         (start),
    .step_mode     (step_mode),
    .step          (step),
    .abort         (abort),
    .vec           (vec),
    .dut_resp      (dut_resp),
    .exp_resp      (exp_resp),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt)
`ifdef VECTOR_SWEEPER_FAIL_CAPTURE_EN
    ,
    .first_fail    (first_fail),
    .first_fail_vld(first_fail_vld)
`endif
  );

  vector_sweeper #(.WIDTH(W2), .OUTW(OW), .HOLD(H2)) dut2 (
    .MAX10_CLK1_50 (clk),
    .RESET_N       (rst_n),
    .start         (start2),
    .step_mode     (1'b0),
    .step          (1'b0),
    .abort         (1'b0),
    .vec           (vec2),
    .dut_resp      (dut_resp2),
    .exp_resp      (exp_resp2),
    .busy          (busy2),
    .done          (done2),
    .pass          (pass2),
    .err_cnt       (err_cnt2)
`ifdef VECTOR_SWEEPER_FAIL_CAPTURE_EN
    ,
    .first_fail    (first_fail2),
    .first_fail_vld(first_fail_vld2)
`endif
  );

  int checks = 0;
  int errors = 0;
  int vq[$];   // expected vector sequence
  int rq[$];   // expected err_cnt at done

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Free-run sweep on the main instance; scoreboard of vector order and hold lengths.
  task automatic run_free(input logic [15:0] mask);
    int cyc;
    int run;
    int ev;
    int er;
    int lo;
    logic [W-1:0] cur;
    bad_mask  = mask;
    step_mode = 1'b0;
    for (int i = 0; i < 16; i++) vq.push_back(i);
    rq.push_back($countones(mask));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_vec", 32'(vec), 32'd0);
    cur = vec;
    run = 1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
      if (done === 1'b1 || vec !== cur) begin
        ev = (vq.size() != 0) ? vq.pop_front() : -1;
        check("vec_val", 32'(cur), 32'(ev));
        check("vec_hold", 32'(run), 32'(H));
        cur = vec;
        run = 1;
      end else begin
        run++;
      end
    end
    check("sweep_len", 32'(cyc), 32'(16 * H));
    check("done", 32'(done), 32'd1);
    check("vq_empty", 32'(vq.size()), 32'd0);
    vq.delete();
    er = rq.pop_front();
    check("err_cnt", 32'(err_cnt), 32'(er));
    check("pass", 32'(pass), 32'(er == 0));
`ifdef VECTOR_SWEEPER_FAIL_CAPTURE_EN
    lo = 0;
    for (int i = 15; i >= 0; i--) if (mask[i]) lo = i;
    check("ff_vld", 32'(first_fail_vld), 32'(mask != 0));
    check("ff_vec", 32'(first_fail), 32'(lo));
`else
    lo = 0;
`endif
    repeat (5) tick();
    check("done_hold_vec", 32'(vec), 32'd15);
    check("done_hold_err", 32'(err_cnt), 32'(er));
    check("done_hold_pass", 32'(pass), 32'(er == 0));
    check("done_hold_done", 32'(done), 32'd1 + 32'(lo - lo));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0;
    start2 = 1'b0; bad_mask = '0;
    repeat (3) tick();
    check("rst_vec", 32'(vec), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // clean sweep, then mismatches at 5 and 12
    run_free(16'h0000);
    run_free(16'h1020);

    // abort during the SAMPLE cycle of vec 7, which mismatches
    bad_mask = 16'h0088;
    start = 1'b1; tick(); start = 1'b0;
    repeat (79) tick();
    check("ab_pre_vec", 32'(vec), 32'd7);
    check("ab_pre_err", 32'(err_cnt), 32'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("ab_vec", 32'(vec), 32'd0);
    check("ab_err", 32'(err_cnt), 32'd1);
    check("ab_done", 32'(done), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("ab_idle_vec", 32'(vec), 32'd0);

    // single-step mode
    bad_mask = '0;
    step_mode = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    step_mode = 1'b0;
    repeat (10) tick();
    repeat (50) tick();
    check("st_wait_vec", 32'(vec), 32'd0);
    check("st_wait_busy", 32'(busy), 32'd0);
    check("st_wait_done", 32'(done), 32'd0);
    step = 1'b1; tick(); step = 1'b0;
    check("st_step_vec", 32'(vec), 32'd1);
    check("st_step_busy", 32'(busy), 32'd1);
    repeat (2) tick();
    step = 1'b1; tick(); step = 1'b0;
    check("st_ign_vec", 32'(vec), 32'd1);
    repeat (8) tick();
    check("st_park_vec", 32'(vec), 32'd1);
    check("st_park_busy", 32'(busy), 32'd0);
    abort = 1'b1; tick(); abort = 1'b0;
    check("st_abort_vec", 32'(vec), 32'd0);

    // reset mid-hold at vec 9 with one error already counted
    bad_mask = 16'h0004;
    start = 1'b1; tick(); start = 1'b0;
    repeat (94) tick();
    check("rs_pre_vec", 32'(vec), 32'd9);
    check("rs_pre_err", 32'(err_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rs_vec", 32'(vec), 32'd0);
    check("rs_err", 32'(err_cnt), 32'd0);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    check("rs_pass", 32'(pass), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_free(16'h0000);   // start lands on the second edge after release

    // WIDTH=2 instance, every vector mismatching, start during APPLY ignored
    start2 = 1'b1; tick(); start2 = 1'b0;
    repeat (6) tick();
    check("w2_pre_vec", 32'(vec2), 32'd2);
    check("w2_pre_busy", 32'(busy2), 32'd1);
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("w2_ign_vec", 32'(vec2), 32'd2);
    cyc = 7;
    while (done2 !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("w2_len", 32'(cyc), 32'(4 * H2));
    check("w2_err", 32'(err_cnt2), 32'd4);
    check("w2_pass", 32'(pass2), 32'd0);
    check("w2_vec", 32'(vec2), 32'd3);
`ifdef VECTOR_SWEEPER_FAIL_CAPTURE_EN
    check("w2_ff_vld", 32'(first_fail_vld2), 32'd1);
    check("w2_ff_vec", 32'(first_fail2), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_sweeper.md
VECTOR_SWEEPER -- requirements
Module: vector_sweeper

Interface
REQ-001 Parameter WIDTH, default 4: stimulus vector width in bits; legal range 1..16.
REQ-002 Parameter OUTW, default 1: width of the device-under-test (DUT) response; legal range 1..16.
REQ-003 Parameter HOLD, default 10: clock cycles each vector is held; legal range 2..65535.
REQ-004 MAX10_CLK1_50  in  1  single system clock; all logic is rising-edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a sweep; honoured only in IDLE or DONE.
REQ-007 step_mode  in  1  1 = single-step mode, 0 = free-run mode; sampled on the start pulse.
REQ-008 step  in  1  one-cycle pulse that advances to the next vector in single-step mode.
REQ-009 abort  in  1  one-cycle pulse that returns the block to IDLE from any state.
REQ-010 vec  out  WIDTH  stimulus driven to the DUT.
REQ-011 dut_resp  in  OUTW  DUT response.
REQ-012 exp_resp  in  OUTW  golden response for the current vec.
REQ-013 busy  out  1  high in APPLY and SAMPLE.
REQ-014 done  out  1  high in DONE.
REQ-015 pass  out  1  high in DONE when err_cnt == 0.
REQ-016 err_cnt  out  WIDTH+1  count of mismatching vectors; saturates at all-ones.

Function
REQ-017 States: IDLE, APPLY, SAMPLE, WAIT_STEP, DONE.
REQ-018 In IDLE or DONE, start moves to APPLY, sets vec=0, clears err_cnt and loads the hold timer with HOLD-1.
REQ-019 In APPLY, the hold timer decrements each cycle; at 0 the state moves to SAMPLE.
REQ-020 vec is held for exactly HOLD cycles: HOLD-1 cycles in APPLY plus 1 cycle in SAMPLE.
REQ-021 In SAMPLE, dut_resp is compared to exp_resp, and err_cnt increments by 1 on mismatch unless it is saturated.
REQ-022 In SAMPLE with vec == 2^WIDTH-1, the next state is DONE and vec holds its value; there is no wrap to 0.
REQ-023 In SAMPLE otherwise: in free-run mode, vec increments and the state returns to APPLY; in step mode, the state moves to WAIT_STEP.
REQ-024 In WAIT_STEP, step increments vec, reloads the timer and moves to APPLY; with no step, vec holds.
REQ-025 step pulses outside WAIT_STEP are ignored.
REQ-026 start pulses outside IDLE and DONE are ignored.
REQ-027 abort has priority over start, step and the sample update in the same cycle: the next state is IDLE, vec=0, and err_cnt retains its value.
REQ-028 A sample-cycle mismatch that coincides with abort is not counted.
REQ-029 In DONE, vec, err_cnt and pass hold until the next start or abort.
REQ-030 The complete sweep in free-run mode takes 2^WIDTH*HOLD cycles from the cycle after start to done=1.

Reset
REQ-031 Reset asserted places the block in IDLE with vec=0, err_cnt=0, busy=0, done=0, pass=0 and the hold timer at 0.
REQ-032 Reset asserted mid-sweep takes effect immediately and asynchronously, and no partial count survives.
REQ-033 Release of reset is synchronised to MAX10_CLK1_50, and the first start is accepted on the second edge after release.

Configuration
REQ-034 Macro VECTOR_SWEEPER_FAIL_CAPTURE_EN, when defined, adds output first_fail (width WIDTH) and output first_fail_vld (width 1).
REQ-035 first_fail_vld is cleared on start and on reset.
REQ-036 On the first counted mismatch of a sweep, first_fail latches vec and first_fail_vld sets; both then hold until the next start or reset.
REQ-037 When VECTOR_SWEEPER_FAIL_CAPTURE_EN is not defined, neither output exists and no capture register is synthesised.

Structure
REQ-038 Package sweep_pkg holds the state enumeration, the default values of WIDTH, OUTW and HOLD, and the timer width constant (16).
REQ-039 Sub-module hold_timer is a loadable down-counter with load, load value, enable and zero-flag ports; vector_sweeper instantiates it once.

Verification
REQ-040 WIDTH=4, HOLD=10, free-run, with dut_resp tied to exp_resp: done rises 160 cycles after start, pass=1, err_cnt=0, and vec steps 0..15, each value held exactly 10 cycles.
REQ-041 WIDTH=4 with a forced mismatch at vec=5 and vec=12: err_cnt=2 and pass=0; with VECTOR_SWEEPER_FAIL_CAPTURE_EN defined, first_fail=5 and first_fail_vld=1.
REQ-042 Step mode: after start, vec=0 is applied; the bench holds off step for 50 cycles and vec remains 0; one step pulse gives vec=1, and a second step pulse inside APPLY is ignored.
REQ-043 Abort in the SAMPLE cycle of vec=7 while that sample mismatches: the next state is IDLE, vec=0, err_cnt is unchanged, and done=0.
REQ-044 RESET_N asserted low at vec=9 mid-hold: all outputs are 0 within the same cycle, and a following start restarts the sweep at vec=0 with err_cnt=0.
REQ-045 Saturation with WIDTH=2 and all vectors mismatching: err_cnt=4, pass=0; a start pulse during APPLY is ignored.
